uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It detects frame completion from the receiver's busy output (high-to-low transition) and pushes the receiver's latched byte into a circular FIFO. The host side drains the FIFO through a first-word-fall-through read port. The block also reports fill level, full/empty status, and a sticky overrun flag.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 1..8
DATA_WIDTH, 8, width of one stored byte; must match the receiver's latched data width

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
rx_busy  input  1  receiver busy; a falling edge marks a completed frame
rx_byte  input  DATA_WIDTH  receiver latched data; stable while rx_busy is low
rd_en  input  1  pop the head entry this cycle
clr_overrun  input  1  clear the sticky overrun flag
rd_data  output  DATA_WIDTH  head entry (FWFT); valid only when empty=0
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds 2^DEPTH_LOG2 entries
level  output  DEPTH_LOG2+1  current entry count, 0..2^DEPTH_LOG2
overrun  output  1  sticky: a completed frame was dropped because the FIFO was full

Behaviour:
- Reset:
  - wr_ptr, rd_ptr, level, busy_q and overrun are cleared to 0, so empty=1 and full=0.
  - rd_data is 0 while empty (masked).
  - Storage contents are not reset.
- Push detection:
  - busy_q <= rx_busy every cycle.
  - push = busy_q & ~rx_busy, which lasts exactly one cycle per frame.
  - A frame already in progress when reset releases (rx_busy high at release) is still pushed on its falling edge.
  - If rx_busy is low at reset release, no spurious push occurs, because busy_q resets to 0.
- Write latency: rx_byte is sampled in the push cycle. On the following cycle, empty=0, level has incremented and rd_data shows the byte if the FIFO was empty.
- Read:
  - rd_data = mem[rd_ptr], combinational from the pointer.
  - rd_en with empty=0 advances rd_ptr at the clock edge, and the next entry appears on the following cycle.
  - rd_en with empty=1 is ignored: no pointer change, no error.
- Pointers: each is DEPTH_LOG2 bits and wraps modulo 2^DEPTH_LOG2. level is tracked in a separate counter; full and empty are decoded from level.
- Simultaneous push and pop:
  - Not full, not empty: both proceed, level is unchanged.
  - Full: the pop frees the slot, so the push is accepted, level stays at max and overrun is not set.
  - Empty: the push is accepted and the pop is ignored, so level becomes 1.
- Overflow: a push while full with no pop drops the byte, leaves the pointers unchanged and sets overrun.
- overrun clearing:
  - overrun stays set until clr_overrun=1.
  - If clr_overrun and an overflow occur in the same cycle, overrun remains 1 (set wins).
- Reset mid-operation discards all buffered data; the next push writes entry 0.

Optional Feature:
Macro: UART_RX_FIFO_WATERMARK_EN
- Defined:
  - Adds input wm_thresh (DEPTH_LOG2+1 bits) and output wm_irq (1 bit, registered, resets to 0).
  - wm_irq = (level_next >= wm_thresh) & (wm_thresh != 0), updated every cycle, so it asserts in the same cycle that level reaches the threshold.
- Undefined: neither port exists and there is no watermark logic.

Test Plan:
- Single frame: reset, then rx_byte=8'hA5 with rx_busy 1->0 -> one cycle later empty=0, level=1, rd_data=8'hA5; pulse rd_en -> empty=1, level=0 the next cycle.
- Ordering and wrap: with DEPTH_LOG2=2, push 0x01..0x04 (full=1, level=4), pop 2, push 0x05 and 0x06, pop all -> rd_data sequence is 01,02,03,04,05,06 and empty=1 at the end.
- Overflow: fill 16 entries, push 0xEE -> overrun=1, level=16, 0xEE never read. Assert clr_overrun together with another overflowing push -> overrun stays 1. clr_overrun alone -> overrun=0.
- Simultaneous events:
  - Full FIFO, push 0x77 in the same cycle as rd_en -> level stays 16, overrun=0, 0x77 is the last byte read.
  - Empty FIFO, push in the same cycle as rd_en -> level=1.
- Reset behaviour:
  - Reset with 5 entries buffered -> level=0, empty=1.
  - rx_busy held low through reset release -> no push.
  - rx_busy high at release then falls with 0x3C -> level=1, rd_data=0x3C.
- Watermark (macro defined): wm_thresh=3, push 3 frames -> wm_irq rises in the cycle level reaches 3; one pop -> wm_irq=0. With wm_thresh=0, wm_irq never asserts.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: pushes on rx_busy falling edge, FWFT read port.
// Optional watermark interrupt (wm_thresh / wm_irq) enabled by defining UART_RX_FIFO_WATERMARK_EN.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_busy,
    input  logic [DATA_WIDTH-1:0] rx_byte,
    input  logic                  rd_en,
    input  logic                  clr_overrun,
`ifdef UART_RX_FIFO_WATERMARK_EN
    input  logic [DEPTH_LOG2:0]   wm_thresh,
    output logic                  wm_irq,
`endif
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overrun
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_busy_q;
    logic                  r_overrun;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_drop;
    logic [LW-1:0]         w_level_next;

    // Push/pop qualification; a pop on a full FIFO frees the slot for a same-cycle push
    always_comb begin
        w_empty      = (r_level == '0);
        w_full       = (r_level == LW'(DEPTH));
        w_push       = r_busy_q & ~rx_busy;
        w_pop        = rd_en & ~w_empty;
        w_accept     = w_push & (~w_full | w_pop);
        w_drop       = w_push & w_full & ~w_pop;
        w_level_next = r_level;
        if (w_accept && !w_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (!w_accept && w_pop) begin
            w_level_next = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_busy_q  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_busy_q <= rx_busy;
            r_level  <= w_level_next;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_mem[r_wr_ptr] <= rx_byte;
        end
    end

`ifdef UART_RX_FIFO_WATERMARK_EN
    logic r_wm_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wm_irq <= 1'b0;
        end else begin
            r_wm_irq <= (w_level_next >= wm_thresh) && (wm_thresh != '0);
        end
    end

    assign wm_irq = r_wm_irq;
`endif

    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty   = w_empty;
    assign full    = w_full;
    assign level   = r_level;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner sequences, randomized traffic vs queue model.
module tb_uart_rx_fifo;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 1 << DL2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_busy = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overrun;
`ifdef UART_RX_FIFO_WATERMARK_EN
    logic [4:0] wm_thresh = 5'd3;
    logic       wm_irq;
`endif

    uart_rx_fifo #(.DEPTH_LOG2(DL2), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_busy     (rx_busy),
        .rx_byte     (rx_byte),
        .rd_en       (rd_en),
        .clr_overrun (clr_overrun),
`ifdef UART_RX_FIFO_WATERMARK_EN
        .wm_thresh   (wm_thresh),
        .wm_irq      (wm_irq),
`endif
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of received bytes, previous busy level, sticky flag
    logic [7:0] m_q[$];
    logic       m_prev_busy = 1'b0;
    logic       m_ovr = 1'b0;

    typedef struct {
        logic       busy;
        logic [7:0] d;
        logic       rd;
        logic       clr;
        int         exp_level;
        logic       exp_empty;
        logic [7:0] exp_rd;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " level"}, 32'(level), 32'(m_q.size()));
        chk({tag, " empty"}, 32'(empty), 32'(m_q.size() == 0));
        chk({tag, " full"}, 32'(full), 32'(m_q.size() == DEPTH));
        chk({tag, " rd_data"}, 32'(rd_data), (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]));
        chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_FIFO_WATERMARK_EN
        chk({tag, " wm_irq"}, 32'(wm_irq), 32'(m_q.size() >= 3));
`endif
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, leave time at posedge+1
    task automatic cyc(input logic b, input logic [7:0] d, input logic rd, input logic clr);
        logic push;
        logic dropped;
        @(negedge clk);
        rx_busy = b; rx_byte = d; rd_en = rd; clr_overrun = clr;
        @(posedge clk);
        push    = m_prev_busy && !b;
        dropped = 1'b0;
        if (rd && m_q.size() != 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else dropped = 1'b1;
        end
        if (dropped) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        m_prev_busy = b;
        #1;
    endtask

    task automatic frame(input logic [7:0] d, input logic rd, input logic clr);
        cyc(1'b1, d, 1'b0, 1'b0);
        cyc(1'b0, d, rd, clr);
    endtask

    task automatic do_reset(input logic b);
        @(negedge clk);
        reset = 1'b1; rx_busy = b; rd_en = 1'b0; clr_overrun = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        m_q.delete();
        m_ovr = 1'b0;
        m_prev_busy = b;
        #1;
    endtask

    logic [7:0] last_rd;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 0, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'h5A, 1'b0, 1'b0, 0, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 8'h5A, 1'b1, 1'b0, 1, 1'b0, 8'h5A, 1'b0};
        vecs[6] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1, 1'b0, 8'h5A, 1'b0};
        vecs[7] = '{1'b0, 8'hC3, 1'b0, 1'b0, 2, 1'b0, 8'h5A, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'hC3, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0};

        do_reset(1'b0);
        chk("reset level", 32'(level), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);

        // Directed vector table: single frame, empty read, simultaneous push+pop on empty
        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].busy, vecs[i].d, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
        end

        // Fill, overflow, clear-vs-set priority, full push+pop
        for (int i = 0; i < DEPTH; i++) begin
            frame(8'(i + 1), 1'b0, 1'b0);
            check_model("fill");
        end
        chk("fill full", 32'(full), 32'd1);
        chk("fill level", 32'(level), 32'd16);
        frame(8'hEE, 1'b0, 1'b0);
        chk("ovf overrun", 32'(overrun), 32'd1);
        chk("ovf level", 32'(level), 32'd16);
        frame(8'hEF, 1'b0, 1'b1);
        chk("ovf+clr overrun", 32'(overrun), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr overrun", 32'(overrun), 32'd0);
        frame(8'h77, 1'b1, 1'b0);
        chk("full push+pop level", 32'(level), 32'd16);
        chk("full push+pop overrun", 32'(overrun), 32'd0);
        chk("full push+pop head", 32'(rd_data), 32'h02);
        last_rd = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last_rd = rd_data;
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check_model("drain");
        end
        chk("drain last byte", 32'(last_rd), 32'h77);
        chk("drain empty", 32'(empty), 32'd1);

        // Reset with data buffered, then busy low / high across release
        for (int i = 0; i < 5; i++) frame(8'(8'h40 + i), 1'b0, 1'b0);
        chk("pre-reset level", 32'(level), 32'd5);
        do_reset(1'b0);
        chk("mid reset level", 32'(level), 32'd0);
        chk("mid reset empty", 32'(empty), 32'd1);
        repeat (3) cyc(1'b0, 8'h99, 1'b0, 1'b0);
        chk("low-at-release no push", 32'(level), 32'd0);
        do_reset(1'b1);
        cyc(1'b0, 8'h3C, 1'b0, 1'b0);
        chk("high-at-release level", 32'(level), 32'd1);
        chk("high-at-release rd_data", 32'(rd_data), 32'h3C);
        check_model("post-reset");

        // Randomized traffic with varying read pressure
        for (int i = 0; i < 3000; i++) begin
            int unsigned rd_pct;
            case ((i / 400) % 3)
                0:       rd_pct = 10;
                1:       rd_pct = 50;
                default: rd_pct = 90;
            endcase
            if ($urandom_range(0, 999) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                cyc($urandom_range(0, 1) == 1, 8'($urandom),
                    $urandom_range(0, 99) < rd_pct, $urandom_range(0, 19) == 0);
            end
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
